// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for the EX stage: signed/unsigned,
// one quotient bit per cycle, {remainder, quotient} result with zero-divisor flag.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign1_q;
  logic             sign2_q;
  logic             signed_q;

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] abs1_c;
  logic [WIDTH-1:0] abs2_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;

  // Datapath: operand magnitudes, one trial subtraction, final sign fix-up.
  always_comb begin
    abs1_c    = opdata1_i;
    abs2_c    = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) abs1_c = ~opdata1_i + WIDTH'(1);
    if (signed_div_i && opdata2_i[WIDTH-1]) abs2_c = ~opdata2_i + WIDTH'(1);
    // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    trial_c   = shifted_c - {1'b0, dvs_q};
    q_fix_c   = quo_q;
    r_fix_c   = rem_q;
    if (signed_q && (sign1_q ^ sign2_q)) q_fix_c = ~quo_q + WIDTH'(1);
    if (signed_q && sign1_q)             r_fix_c = ~rem_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            if (opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              state    <= RUN;
              cnt      <= '0;
              rem_q    <= '0;
              quo_q    <= abs1_c;
              dvs_q    <= abs2_c;
              sign1_q  <= opdata1_i[WIDTH-1];
              sign2_q  <= opdata2_i[WIDTH-1];
              signed_q <= signed_div_i;
            end
          end
        end
        ZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state      <= DONE;
            ready_o    <= 1'b1;
            div_zero_o <= 1'b1;
            result_o   <= '0;
          end
        end
        RUN: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == CW'(WIDTH)) begin
            state      <= DONE;
            busy_o     <= 1'b0;
            ready_o    <= 1'b1;
            div_zero_o <= 1'b0;
            result_o   <= {r_fix_c, q_fix_c};
          end else begin
            // Negative trial result (borrow out) means restore.
            rem_q <= trial_c[WIDTH] ? shifted_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
            cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!start_i) begin
            state      <= IDLE;
            ready_o    <= 1'b0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
